// File: rtl/williams2_pkg.sv
// Shared types and default sizing for the Williams-2 ROM download sequencer.
package williams2_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_FAULT
    } state_e;

    localparam logic [17:0] EXP_LEN_DEF       = 18'd172032;
    localparam logic [15:0] SETTLE_CYCLES_DEF = 16'd1024;
    localparam logic [17:0] BYTE_COUNT_MAX    = 18'h3FFFF;

    function automatic logic [17:0] sat_inc(input logic [17:0] v);
        return (v == BYTE_COUNT_MAX) ? v : v + 18'd1;
    endfunction

endpackage

// File: rtl/dl_sequencer.sv
// Forwards an index-0 HPS download into the core's ROM, validates its length,
// and holds the core in reset until a good image has settled.
module dl_sequencer
    import williams2_pkg::*;
#(
    parameter logic [17:0] EXP_LEN       = EXP_LEN_DEF,
    parameter logic [15:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic        clock_12,
    input  logic        reset,
    input  logic        dl_active,
    input  logic [15:0] dl_index,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        user_reset,
    output logic [17:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_err,
    output logic [17:0] byte_count
);

    state_e      state_q, state_d;
    logic        dl_active_q, dl_active_d;
    logic        armed_q, armed_d;
    logic [17:0] byte_count_q, byte_count_d;
    logic        ovf_q, ovf_d;
    logic        rom_err_q, rom_err_d;
    logic [15:0] settle_q, settle_d;
    logic        dn_wr_q, dn_wr_d;
    logic [17:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        core_reset_q, core_reset_d;
    logic        dl_rise, dl_fall;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        dl_active_d  = dl_active;
        // A download already in progress when reset lifts must not look like a fresh rise.
        armed_d      = armed_q | ~dl_active;
        byte_count_d = byte_count_q;
        ovf_d        = ovf_q;
        rom_err_d    = rom_err_q;
        settle_d     = settle_q;
        dn_wr_d      = 1'b0;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dl_rise      = dl_active & ~dl_active_q & armed_q;
        dl_fall      = ~dl_active & dl_active_q;

        case (state_q)
            ST_LOAD: begin
                if (dl_wr) begin
                    if (dl_addr < {7'd0, EXP_LEN}) begin
                        dn_wr_d      = 1'b1;
                        dn_addr_d    = dl_addr[17:0];
                        dn_data_d    = dl_data;
                        byte_count_d = sat_inc(byte_count_q);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // Judge on the _d values so a write coinciding with the fall is counted.
                if (dl_fall) begin
                    if (byte_count_d == EXP_LEN && !ovf_d) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_CYCLES - 16'd1;
                    end else begin
                        state_d   = ST_FAULT;
                        rom_err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == 16'd0) state_d  = ST_RUN;
                else                   settle_d = settle_q - 16'd1;
            end
            default: ;
        endcase

        if (dl_rise && dl_index == 16'd0) begin
            state_d      = ST_LOAD;
            byte_count_d = 18'd0;
            ovf_d        = 1'b0;
            rom_err_d    = 1'b0;
        end

        core_reset_d = (state_d != ST_RUN) | user_reset;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            dl_active_q  <= 1'b0;
            armed_q      <= 1'b0;
            byte_count_q <= 18'd0;
            ovf_q        <= 1'b0;
            rom_err_q    <= 1'b0;
            settle_q     <= 16'd0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= 18'd0;
            dn_data_q    <= 8'd0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            dl_active_q  <= dl_active_d;
            armed_q      <= armed_d;
            byte_count_q <= byte_count_d;
            ovf_q        <= ovf_d;
            rom_err_q    <= rom_err_d;
            settle_q     <= settle_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign rom_ok     = (state_q == ST_RUN);
    assign rom_err    = rom_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// Directed bench for dl_sequencer (EXP_LEN=16, SETTLE_CYCLES=4); ROM writes are
// checked by a scoreboard monitor, status outputs by direct checks.
module tb_dl_sequencer;

    logic        clock_12 = 1'b0;
    logic        reset;
    logic        dl_active;
    logic [15:0] dl_index;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        user_reset;
    logic [17:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        rom_ok;
    logic        rom_err;
    logic [17:0] byte_count;

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      cyc      = 0;
    int      checks   = 0;
    int      failures = 0;

    dl_sequencer #(
        .EXP_LEN       (18'd16),
        .SETTLE_CYCLES (16'd4)
    ) dut (
        .clock_12   (clock_12),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_index   (dl_index),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .user_reset (user_reset),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_wr      (dn_wr),
        .core_reset (core_reset),
        .rom_ok     (rom_ok),
        .rom_err    (rom_err),
        .byte_count (byte_count)
    );

    always #5 clock_12 = ~clock_12;

    // Monitor: every dn_wr must match the oldest expected write, one cycle after issue.
    always @(posedge clock_12) begin
        wr_exp_t e;
        cyc = cyc + 1;
        #1;
        if (dn_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dn_wr_unexpected got addr=%0h data=%0h expected no write", dn_addr, dn_data);
            end else begin
                e = exp_q.pop_front();
                if (dn_addr !== e.addr || dn_data !== e.data || cyc != e.cyc)
                begin
                    failures++;
                    $display("FAIL dn_wr got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                             dn_addr, dn_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_12);
    endtask

    task automatic start_dl(input logic [15:0] idx);
        dl_index  = idx;
        dl_active = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit fwd);
        wr_exp_t e;
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        if (fwd) begin
            e.addr = a[17:0];
            e.data = d;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        dl_wr = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        dl_active  = 1'b0;
        dl_index   = 16'd0;
        dl_wr      = 1'b0;
        dl_addr    = 25'd0;
        dl_data    = 8'd0;
        user_reset = 1'b0;
        repeat (3) tick();
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_rom_ok",     {31'd0, rom_ok},     32'd0);
        check("rst_rom_err",    {31'd0, rom_err},    32'd0);
        check("rst_byte_count", {14'd0, byte_count}, 32'd0);
        check("rst_dn_addr",    {14'd0, dn_addr},    32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Good load of 16 bytes.
        start_dl(16'd0);
        for (int i = 0; i < 16; i++) wr(25'(i), 8'(8'hA0 + i), 1'b1);
        end_dl();
        check("good_byte_count", {14'd0, byte_count}, 32'd16);
        check("good_settle_core_reset", {31'd0, core_reset}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("good_settle_rom_ok", {31'd0, rom_ok}, 32'd0);
            tick();
        end
        check("good_settle_last_rom_ok", {31'd0, rom_ok}, 32'd0);
        tick();
        check("good_run_rom_ok",     {31'd0, rom_ok},     32'd1);
        check("good_run_core_reset", {31'd0, core_reset}, 32'd0);
        check("good_run_rom_err",    {31'd0, rom_err},    32'd0);

        // user_reset passes through in RUN with one cycle of latency.
        user_reset = 1'b1;
        tick();
        check("user_reset_core_reset", {31'd0, core_reset}, 32'd1);
        check("user_reset_rom_ok",     {31'd0, rom_ok},     32'd1);
        user_reset = 1'b0;
        tick();
        check("user_release_core_reset", {31'd0, core_reset}, 32'd0);

        // Non-zero index is ignored.
        start_dl(16'd1);
        for (int i = 0; i < 4; i++) wr(25'(i), 8'h55, 1'b0);
        end_dl();
        dl_index = 16'd0;
        check("idx1_rom_ok",     {31'd0, rom_ok},     32'd1);
        check("idx1_byte_count", {14'd0, byte_count}, 32'd16);
        check("idx1_core_reset", {31'd0, core_reset}, 32'd0);

        // Reload from RUN, then a short load.
        start_dl(16'd0);
        check("reload_core_reset", {31'd0, core_reset}, 32'd1);
        check("reload_byte_count", {14'd0, byte_count}, 32'd0);
        check("reload_rom_ok",     {31'd0, rom_ok},     32'd0);
        for (int i = 0; i < 15; i++) wr(25'(i), 8'(8'h10 + i), 1'b1);
        end_dl();
        check("short_rom_err",    {31'd0, rom_err},    32'd1);
        check("short_rom_ok",     {31'd0, rom_ok},     32'd0);
        check("short_core_reset", {31'd0, core_reset}, 32'd1);
        check("short_byte_count", {14'd0, byte_count}, 32'd15);
        user_reset = 1'b1;
        repeat (2) tick();
        user_reset = 1'b0;
        tick();
        check("fault_hold_rom_err",    {31'd0, rom_err},    32'd1);
        check("fault_hold_core_reset", {31'd0, core_reset}, 32'd1);
        check("fault_hold_rom_ok",     {31'd0, rom_ok},     32'd0);

        // Overflow: a write past the image end is dropped and faults the load.
        start_dl(16'd0);
        check("ovf_start_rom_err",    {31'd0, rom_err},    32'd0);
        check("ovf_start_byte_count", {14'd0, byte_count}, 32'd0);
        for (int i = 0; i < 16; i++) wr(25'(i), 8'(8'h30 + i), 1'b1);
        wr(25'd20, 8'hEE, 1'b0);
        end_dl();
        check("ovf_rom_err",    {31'd0, rom_err},    32'd1);
        check("ovf_byte_count", {14'd0, byte_count}, 32'd16);
        check("ovf_rom_ok",     {31'd0, rom_ok},     32'd0);

        // Last write coincides with the fall; then async reset mid-SETTLE.
        start_dl(16'd0);
        for (int i = 0; i < 15; i++) wr(25'(i), 8'(8'h60 + i), 1'b1);
        dl_active = 1'b0;
        wr(25'd15, 8'h6F, 1'b1);
        check("coinc_byte_count", {14'd0, byte_count}, 32'd16);
        check("coinc_rom_err",    {31'd0, rom_err},    32'd0);
        check("coinc_core_reset", {31'd0, core_reset}, 32'd1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_byte_count", {14'd0, byte_count}, 32'd0);
        check("arst_dn_addr",    {14'd0, dn_addr},    32'd0);
        check("arst_dn_data",    {24'd0, dn_data},    32'd0);
        check("arst_dn_wr",      {31'd0, dn_wr},      32'd0);
        check("arst_core_reset", {31'd0, core_reset}, 32'd1);
        check("arst_rom_ok",     {31'd0, rom_ok},     32'd0);
        check("arst_rom_err",    {31'd0, rom_err},    32'd0);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("boot_after_rst_rom_ok", {31'd0, rom_ok}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl_sequencer.md
DL_SEQUENCER -- requirements
Module: dl_sequencer

Interface
REQ-001 SHALL have parameter EXP_LEN, default 18'd172032; meaning: exact ROM image length in bytes for index 0.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16'd1024; meaning: clock_12 cycles the core stays in reset after a good load.
REQ-003 SHALL have port clock_12  in  1  system clock; the only clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high.
REQ-005 SHALL have port dl_active  in  1  HPS download in progress.
REQ-006 SHALL have port dl_index  in  16  download index.
REQ-007 SHALL have port dl_wr  in  1  one-cycle byte write strobe.
REQ-008 SHALL have port dl_addr  in  25  byte address.
REQ-009 SHALL have port dl_data  in  8  byte data.
REQ-010 SHALL have port user_reset  in  1  reset request from OSD/button.
REQ-011 SHALL have port dn_addr  out  18  ROM write address to the game core.
REQ-012 SHALL have port dn_data  out  8  ROM write data.
REQ-013 SHALL have port dn_wr  out  1  ROM write strobe.
REQ-014 SHALL have port core_reset  out  1  reset to the game core.
REQ-015 SHALL have port rom_ok  out  1  image loaded, core running.
REQ-016 SHALL have port rom_err  out  1  last load was short, long or out of range.
REQ-017 SHALL have port byte_count  out  18  bytes accepted in the current/last load.

Function
REQ-018 SHALL implement states BOOT, LOAD, SETTLE, RUN, FAULT.
REQ-019 SHALL detect the dl_active rising edge against a registered copy; on a rise with dl_index==0, from any state, SHALL enter LOAD, clear byte_count, clear the overflow flag and clear rom_err.
REQ-020 SHALL ignore downloads with dl_index!=0 entirely: no state change and no dn_wr.
REQ-021 In LOAD, SHALL forward dl_wr with dl_addr<EXP_LEN as dn_wr/dn_addr=dl_addr[17:0]/dn_data, registered, exactly one cycle of latency, and SHALL increment byte_count, saturating at 18'h3FFFF.
REQ-022 In LOAD, SHALL drop dl_wr with dl_addr>=EXP_LEN (no dn_wr) and set the overflow flag.
REQ-023 On the dl_active falling edge in LOAD, SHALL go to SETTLE if byte_count==EXP_LEN and overflow is clear, else to FAULT with rom_err=1.
REQ-024 A dl_wr in the same cycle dl_active falls SHALL be accepted and counted before the REQ-023 evaluation.
REQ-025 SETTLE SHALL load the counter with SETTLE_CYCLES-1 on entry, decrement each cycle, and go to RUN the cycle after it reads 0.
REQ-026 core_reset SHALL be 1 in BOOT, LOAD, SETTLE and FAULT; in RUN it SHALL equal user_reset, registered, one cycle of latency.
REQ-027 rom_ok SHALL be 1 only in RUN; rom_err SHALL hold until the next index-0 LOAD entry.
REQ-028 Outside LOAD, SHALL keep dn_wr at 0.
REQ-029 user_reset SHALL NOT leave BOOT, LOAD, SETTLE or FAULT.

Reset
REQ-030 On reset SHALL enter BOOT with dn_addr=0, dn_data=0, dn_wr=0, core_reset=1, rom_ok=0, rom_err=0, byte_count=0, overflow=0, settle counter=0, dl_active edge register=0.
REQ-031 Reset asserted mid-LOAD SHALL abort the load; a load SHALL restart only on a fresh dl_active rise.

Structure
REQ-032 SHALL place the state enum and the EXP_LEN/SETTLE_CYCLES defaults in shared package williams2_pkg.
REQ-033 SHALL be a single module with no sub-module; the settle counter is inline.

Verification (bench with EXP_LEN=16, SETTLE_CYCLES=4)
REQ-034 Good load: 16 writes to addresses 0..15, then dl_active falls -> 16 dn_wr pulses, each one cycle late; byte_count=16; SETTLE lasts 4 cycles; then rom_ok=1 and core_reset=0.
REQ-035 Short load: 15 writes -> FAULT; rom_err=1; core_reset stays 1; rom_ok=0.
REQ-036 Overflow: 16 good writes plus one to address 20 -> no dn_wr for address 20; FAULT; rom_err=1.
REQ-037 Index filter: dl_index=1 with 4 writes while in RUN -> state stays RUN; no dn_wr; byte_count unchanged.
REQ-038 Reload from RUN: a dl_active rise with index 0 -> core_reset=1 the next cycle; byte_count=0; rom_err cleared.
REQ-039 Edge cases: the last write coincides with the dl_active fall -> reaches SETTLE. Async reset in the middle of SETTLE -> BOOT immediately with all outputs at their REQ-030 values.
